// File: rtl/lr_d_seq_pkg.sv
// Shared constants for the leaky-ReLU derivative sequencer.
// FSM state codes are plain localparams so legacy tools can read them.
package lr_d_seq_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam logic [DATA_W_DEF-1:0] DATA_ZERO = '0;

endpackage

// File: rtl/lr_d_seq_delay.sv
// Valid+data shift register of DEPTH stages.
// Data is forced to zero on entry whenever its valid is low, so bubbles carry zeros.
module lr_d_seq_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);

  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0][W-1:0] data_q;

  // Shift valid and zero-gated data one stage per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_in;
      data_q[0]  <= valid_in ? data_in : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];

endmodule

// File: rtl/lr_d_sequencer.sv
// Sequences one backprop activation-derivative pass over the 2-column leaky-ReLU
// derivative unit: accepts gradient beats, fetches H pairs, aligns them, drives
// column 1 then column 2 one cycle later, and counts returned results.
// Optional feature macro: LRD_SEQ_PERF_EN adds the perf_stall_cnt output.
module lr_d_sequencer
  import lr_d_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_leak_we,
  input  logic [DATA_W-1:0] cfg_leak_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] h_base_addr,
  output logic              busy,
  output logic              done,
  input  logic              grad_valid_in,
  output logic              grad_ready_out,
  input  logic [DATA_W-1:0] grad_1_in,
  input  logic [DATA_W-1:0] grad_2_in,
  output logic              h_rd_en,
  output logic [ADDR_W-1:0] h_rd_addr,
  input  logic [DATA_W-1:0] h_1_rdata,
  input  logic [DATA_W-1:0] h_2_rdata,
  output logic [DATA_W-1:0] lr_leak_factor_out,
  output logic              lr_d_valid_1_out,
  output logic              lr_d_valid_2_out,
  output logic [DATA_W-1:0] lr_d_data_1_out,
  output logic [DATA_W-1:0] lr_d_data_2_out,
  output logic [DATA_W-1:0] lr_d_H_1_out,
  output logic [DATA_W-1:0] lr_d_H_2_out,
  input  logic              lr_d_valid_2_in
`ifdef LRD_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     issued_q, returned_q, returned_d, num_ext;
  logic [ADDR_W-1:0]   num_rows_q, base_q;
  logic [DATA_W-1:0]   leak_q;
  logic                accept, ret_fire, start_ok;

  logic                al_valid;
  logic [2*DATA_W-1:0] al_data;
  logic                c1_valid_q;
  logic [DATA_W-1:0]   c1_data_q, c1_h_q;
  logic [2*DATA_W-1:0] c2_pend_q, c2_data;

  assign num_ext        = {1'b0, num_rows_q};
  assign start_ok       = start && (state_q == IDLE);
  assign grad_ready_out = (state_q == RUN) && (issued_q < num_ext);
  assign accept         = grad_valid_in && grad_ready_out;
  assign h_rd_en        = accept;
  assign h_rd_addr      = accept ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign ret_fire       = lr_d_valid_2_in && ((state_q == RUN) || (state_q == DRAIN));
  assign returned_d     = returned_q + {{ADDR_W{1'b0}}, ret_fire};

  // Next-state: the last return is counted in the same cycle it arrives
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_rows == '0) ? DONE : RUN;
      RUN:     if (issued_q == num_ext) state_d = DRAIN;
      DRAIN:   if (returned_d == num_ext) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pass parameters, counters and the leak register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      base_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      leak_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_rows_q <= num_rows;
        base_q     <= h_base_addr;
        issued_q   <= '0;
        returned_q <= '0;
      end else begin
        if (accept) issued_q <= issued_q + (ADDR_W+1)'(1);
        returned_q <= returned_d;
      end
      // Writes while busy are dropped so the factor is stable for the pass
      if (cfg_leak_we && (state_q == IDLE)) leak_q <= cfg_leak_in;
    end
  end

  assign lr_leak_factor_out = leak_q;

  // Gradients wait RD_LAT cycles so they meet the H read data
  lr_d_seq_delay #(
    .DEPTH (RD_LAT),
    .W     (2*DATA_W)
  ) u_grad_align (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (accept),
    .data_in   ({grad_1_in, grad_2_in}),
    .valid_out (al_valid),
    .data_out  (al_data)
  );

  // Column-1 output register; column-2 pair is staged alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1_valid_q <= 1'b0;
      c1_data_q  <= '0;
      c1_h_q     <= '0;
      c2_pend_q  <= '0;
    end else begin
      c1_valid_q <= al_valid;
      c1_data_q  <= al_valid ? al_data[2*DATA_W-1:DATA_W] : '0;
      c1_h_q     <= al_valid ? h_1_rdata : '0;
      c2_pend_q  <= al_valid ? {al_data[DATA_W-1:0], h_2_rdata} : '0;
    end
  end

  // Systolic skew: column 2 trails column 1 by one cycle
  lr_d_seq_delay #(
    .DEPTH (1),
    .W     (2*DATA_W)
  ) u_col2_skew (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (c1_valid_q),
    .data_in   (c2_pend_q),
    .valid_out (lr_d_valid_2_out),
    .data_out  (c2_data)
  );

  assign lr_d_valid_1_out = c1_valid_q;
  assign lr_d_data_1_out  = c1_data_q;
  assign lr_d_H_1_out     = c1_h_q;
  assign lr_d_data_2_out  = c2_data[2*DATA_W-1:DATA_W];
  assign lr_d_H_2_out     = c2_data[DATA_W-1:0];

`ifdef LRD_SEQ_PERF_EN
  logic [15:0] perf_q;

  // Saturating count of RUN cycles where a beat could have been taken but none came
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (grad_ready_out && !grad_valid_in && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_lr_d_sequencer.sv
// Self-checking bench for lr_d_sequencer with a transaction-level reference model.
module tb_lr_d_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_leak_we = 1'b0;
  logic [DW-1:0] cfg_leak_in = '0;
  logic          start = 1'b0;
  logic [AW-1:0] num_rows = '0;
  logic [AW-1:0] h_base_addr = '0;
  logic          busy, done;
  logic          grad_valid_in = 1'b0;
  logic          grad_ready_out;
  logic [DW-1:0] grad_1_in = '0, grad_2_in = '0;
  logic          h_rd_en;
  logic [AW-1:0] h_rd_addr;
  logic [DW-1:0] h_1_rdata, h_2_rdata;
  logic [DW-1:0] lr_leak_factor_out;
  logic          lr_d_valid_1_out, lr_d_valid_2_out;
  logic [DW-1:0] lr_d_data_1_out, lr_d_data_2_out, lr_d_H_1_out, lr_d_H_2_out;
  logic          lr_d_valid_2_in = 1'b0;
`ifdef LRD_SEQ_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  lr_d_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_leak_we        (cfg_leak_we),
    .cfg_leak_in        (cfg_leak_in),
    .start              (start),
    .num_rows           (num_rows),
    .h_base_addr        (h_base_addr),
    .busy               (busy),
    .done               (done),
    .grad_valid_in      (grad_valid_in),
    .grad_ready_out     (grad_ready_out),
    .grad_1_in          (grad_1_in),
    .grad_2_in          (grad_2_in),
    .h_rd_en            (h_rd_en),
    .h_rd_addr          (h_rd_addr),
    .h_1_rdata          (h_1_rdata),
    .h_2_rdata          (h_2_rdata),
    .lr_leak_factor_out (lr_leak_factor_out),
    .lr_d_valid_1_out   (lr_d_valid_1_out),
    .lr_d_valid_2_out   (lr_d_valid_2_out),
    .lr_d_data_1_out    (lr_d_data_1_out),
    .lr_d_data_2_out    (lr_d_data_2_out),
    .lr_d_H_1_out       (lr_d_H_1_out),
    .lr_d_H_2_out       (lr_d_H_2_out),
    .lr_d_valid_2_in    (lr_d_valid_2_in)
`ifdef LRD_SEQ_PERF_EN
    ,
    .perf_stall_cnt     (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // H cache model: one-cycle read latency, garbage when not reading
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];
  always @(posedge clk) begin
    if (h_rd_en) begin
      h_1_rdata <= mem1[h_rd_addr];
      h_2_rdata <= mem2[h_rd_addr];
    end else begin
      h_1_rdata <= DW'($urandom);
      h_2_rdata <= DW'($urandom);
    end
  end

  typedef struct {
    int            t;
    logic [DW-1:0] g;
    logic [DW-1:0] h;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];

  int            ph, m_n, m_base, m_issued, m_returned, m_perf;
  logic [DW-1:0] m_leak;
  int            cur;
  int            checks, errors;
  int            done_seen, done_cyc, last_ret_cyc;
  int            addr_log[$];

  task automatic model_reset();
    ph = PH_IDLE; m_n = 0; m_base = 0; m_issued = 0; m_returned = 0; m_perf = 0;
    m_leak = '0;
    q1.delete();
    q2.delete();
  endtask

  // One clock of stimulus, output checks against the model, then model advance
  task automatic run_cycle(input string tag, input logic gv, input logic st, input int nr,
                           input int base, input logic we, input logic [DW-1:0] lk);
    logic exp_ready, acc, ret, ev1, ev2;
    int   exp_addr, issued_pre;
    ev_t  e1, e2;
    @(posedge clk);
    #1;
    grad_valid_in   = gv;
    grad_1_in       = DW'($urandom);
    grad_2_in       = DW'($urandom);
    start           = st;
    num_rows        = nr[AW-1:0];
    h_base_addr     = base[AW-1:0];
    cfg_leak_we     = we;
    cfg_leak_in     = lk;
    lr_d_valid_2_in = lr_d_valid_2_out;
    @(negedge clk);
    exp_ready = (ph == PH_RUN) && (m_issued < m_n);
    acc       = gv && exp_ready;
    exp_addr  = acc ? (m_base + m_issued) % 256 : 0;

    checks++;
    if ({busy, done, grad_ready_out} !== {ph != PH_IDLE, ph == PH_DONE, exp_ready}) begin
      errors++;
      $display("FAIL %s status cyc=%0d got busy/done/ready=%b want=%b", tag, cur,
               {busy, done, grad_ready_out}, {ph != PH_IDLE, ph == PH_DONE, exp_ready});
    end
    checks++;
    if ({h_rd_en, h_rd_addr} !== {acc, 8'(exp_addr)}) begin
      errors++;
      $display("FAIL %s h_rd cyc=%0d got en=%b addr=%0h want en=%b addr=%0h", tag, cur,
               h_rd_en, h_rd_addr, acc, exp_addr);
    end
    checks++;
    if (lr_leak_factor_out !== m_leak) begin
      errors++;
      $display("FAIL %s leak cyc=%0d got=%0h want=%0h", tag, cur, lr_leak_factor_out, m_leak);
    end

    ev1 = (q1.size() > 0) && (q1[0].t == cur);
    if (ev1) e1 = q1.pop_front(); else e1 = '{cur, '0, '0};
    checks++;
    if ({lr_d_valid_1_out, lr_d_data_1_out, lr_d_H_1_out} !== {ev1, e1.g, e1.h}) begin
      errors++;
      $display("FAIL %s col1 cyc=%0d got v=%b d=%0h h=%0h want v=%b d=%0h h=%0h", tag, cur,
               lr_d_valid_1_out, lr_d_data_1_out, lr_d_H_1_out, ev1, e1.g, e1.h);
    end
    ev2 = (q2.size() > 0) && (q2[0].t == cur);
    if (ev2) e2 = q2.pop_front(); else e2 = '{cur, '0, '0};
    checks++;
    if ({lr_d_valid_2_out, lr_d_data_2_out, lr_d_H_2_out} !== {ev2, e2.g, e2.h}) begin
      errors++;
      $display("FAIL %s col2 cyc=%0d got v=%b d=%0h h=%0h want v=%b d=%0h h=%0h", tag, cur,
               lr_d_valid_2_out, lr_d_data_2_out, lr_d_H_2_out, ev2, e2.g, e2.h);
    end
`ifdef LRD_SEQ_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'(m_perf)) begin
      errors++;
      $display("FAIL %s perf cyc=%0d got=%0d want=%0d", tag, cur, perf_stall_cnt, m_perf);
    end
`endif

    if (done) begin done_seen++; done_cyc = cur; end
    if (h_rd_en) addr_log.push_back(int'(h_rd_addr));
    if (lr_d_valid_2_in) last_ret_cyc = cur;

    // Reference model advance for the coming clock edge
    issued_pre = m_issued;
    if (acc) begin
      q1.push_back('{cur + 2, grad_1_in, mem1[exp_addr]});
      q2.push_back('{cur + 3, grad_2_in, mem2[exp_addr]});
      m_issued++;
    end
    ret = lr_d_valid_2_in && (ph == PH_RUN || ph == PH_DRAIN);
    if (ret) m_returned++;
    case (ph)
      PH_IDLE: begin
        if (we) m_leak = lk;
        if (st) begin
          m_n = nr; m_base = base; m_issued = 0; m_returned = 0; m_perf = 0;
          ph = (nr == 0) ? PH_DONE : PH_RUN;
        end
      end
      PH_RUN: begin
        if (exp_ready && !gv && m_perf < 65535) m_perf++;
        if (issued_pre == m_n) ph = PH_DRAIN;
      end
      PH_DRAIN: if (m_returned == m_n) ph = PH_DONE;
      default:  ph = PH_IDLE;
    endcase
    cur++;
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random; inject pokes start/leak while busy
  task automatic run_pass(input string tag, input int n, input int base, input int mode,
                          input logic inject);
    int   k;
    logic gv, inj;
    done_seen = 0; done_cyc = -1; last_ret_cyc = -1;
    addr_log.delete();
    run_cycle(tag, 1'b0, 1'b1, n, base, 1'b0, '0);
    k = 0;
    while (ph != PH_IDLE && k < 200) begin
      case (mode)
        0:       gv = 1'b1;
        1:       gv = (k % 2 == 0);
        default: gv = ($urandom_range(0, 3) != 0);
      endcase
      inj = inject && (k == 3);
      run_cycle(tag, gv, inj, inj ? 1 : 0, 0, inj, 16'h0010);
      k++;
    end
    run_cycle(tag, 1'b0, 1'b0, 0, 0, 1'b0, '0);
    checks++;
    if (ph != PH_IDLE || k >= 200) begin
      errors++;
      $display("FAIL %s timeout got phase=%0d want=%0d", tag, ph, PH_IDLE);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL %s done_count got=%0d want=1", tag, done_seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({busy, done, grad_ready_out, h_rd_en, h_rd_addr, lr_leak_factor_out, lr_d_valid_1_out,
         lr_d_data_1_out, lr_d_H_1_out, lr_d_valid_2_out, lr_d_data_2_out, lr_d_H_2_out} !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b rdy=%b en=%b v1=%b v2=%b leak=%0h want all 0",
               busy, done, grad_ready_out, h_rd_en, lr_d_valid_1_out, lr_d_valid_2_out,
               lr_leak_factor_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    run_cycle("leak_wr", 1'b0, 1'b0, 0, 0, 1'b1, 16'h0040);
    run_pass("basic", 4, 8, 0, 1'b0);
    checks++;
    if (addr_log.size() != 4) begin
      errors++;
      $display("FAIL basic addr_count got=%0d want=4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[i] != 8 + i) begin
          errors++;
          $display("FAIL basic addr[%0d] got=%0h want=%0h", i, addr_log[i], 8 + i);
        end
      end
    end
    checks++;
    if (done_cyc != last_ret_cyc + 1) begin
      errors++;
      $display("FAIL basic done_timing got=%0d want=%0d", done_cyc, last_ret_cyc + 1);
    end
  endtask

  task automatic test_zero_rows();
    run_pass("zero_rows", 0, 33, 0, 1'b0);
    checks++;
    if (addr_log.size() != 0) begin
      errors++;
      $display("FAIL zero_rows h_rd_en_count got=%0d want=0", addr_log.size());
    end
  endtask

  task automatic test_bubbles();
    run_pass("bubbles", 3, 40, 1, 1'b0);
`ifdef LRD_SEQ_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bubbles perf_final got=%0d want=2", perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    int exp_a[3];
    exp_a[0] = 'hFE; exp_a[1] = 'hFF; exp_a[2] = 'h00;
    run_pass("wrap", 3, 'hFE, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_log.size() != 3 || addr_log[i] != exp_a[i]) begin
        errors++;
        $display("FAIL wrap addr[%0d] got=%0h want=%0h", i,
                 (addr_log.size() > i) ? addr_log[i] : -1, exp_a[i]);
      end
    end
  endtask

  task automatic test_busy_writes();
    run_pass("busy_wr", 6, 100, 0, 1'b1);
    checks++;
    if (lr_leak_factor_out !== 16'h0040) begin
      errors++;
      $display("FAIL busy_wr leak_final got=%0h want=0040", lr_leak_factor_out);
    end
    checks++;
    if (addr_log.size() != 6) begin
      errors++;
      $display("FAIL busy_wr beats got=%0d want=6", addr_log.size());
    end
  endtask

  task automatic test_reset_mid();
    run_cycle("rst_mid", 1'b0, 1'b1, 5, 20, 1'b0, '0);
    run_cycle("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0, '0);
    run_cycle("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0, '0);
    run_cycle("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0, '0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    lr_d_valid_2_in = 1'b0;
    #1;
    checks++;
    if ({busy, done, grad_ready_out, h_rd_en, h_rd_addr, lr_leak_factor_out, lr_d_valid_1_out,
         lr_d_data_1_out, lr_d_H_1_out, lr_d_valid_2_out, lr_d_data_2_out, lr_d_H_2_out} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got busy=%b done=%b rdy=%b en=%b v1=%b v2=%b leak=%0h want all 0",
               busy, done, grad_ready_out, h_rd_en, lr_d_valid_1_out, lr_d_valid_2_out,
               lr_leak_factor_out);
    end
    grad_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_pass("after_rst", 3, 200, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      run_cycle("rand_leak", 1'b0, 1'b0, 0, 0, 1'b1, DW'($urandom));
      run_pass("random", $urandom_range(1, 12), $urandom_range(0, 255), 2, 1'b0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cur = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = DW'($urandom);
      mem2[i] = DW'($urandom);
    end
    model_reset();
    test_reset();
    test_basic();
    test_zero_rows();
    test_bubbles();
    test_wrap();
    test_busy_writes();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
